// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants, TX/RX FSM state types and FIFO level sizing
// shared by uart_fifo and fifo_buf.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_st_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_fifo_buf.sv
// fifo_buf: synchronous show-ahead FIFO, W bits x DEPTH entries.
// Ports: i_clk/i_rst_n; i_push/i_data write side (ignored when full);
// i_pop read side (ignored when empty); o_data head word (0 when empty);
// o_full/o_empty/o_level occupancy.
module fifo_buf import uart_pkg::*; #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [lvl_w(DEPTH)-1:0]    o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == LW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_level = r_cnt;
  // Full is judged before any same-cycle pop, so a pop never makes room for a push.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // Memory is not reset; the head is masked so the output reads 0 while empty.
  assign o_data  = o_empty ? '0 : r_mem[r_rp];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + LW'(w_push) - LW'(w_pop);
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_data;
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART transceiver with TX/RX FIFOs, parity, stop-bit
// count, mid-bit sampling with false-start rejection and internal loopback.
// Ports: i_tx_data/i_tx_valid/o_tx_ready TX stream; o_rx_data/o_rx_valid/
// i_rx_ready RX stream; i_rx/o_tx serial pins; i_loopback routes the TX line
// to the receiver and parks o_tx at 1; o_t_busy/o_r_busy frame activity;
// o_rx_par_err/o_rx_frame_err/o_rx_overrun one-cycle error pulses;
// o_tx_level/o_rx_level FIFO occupancy.
module uart_fifo import uart_pkg::*; #(
  parameter int W     = 8,
  parameter int DIV   = 3,
  parameter int PAR   = 0,
  parameter int STOP  = 1,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [W-1:0]            i_tx_data,
  input  logic                    i_tx_valid,
  output logic                    o_tx_ready,
  output logic [W-1:0]            o_rx_data,
  output logic                    o_rx_valid,
  input  logic                    i_rx_ready,
  input  logic                    i_rx,
  output logic                    o_tx,
  input  logic                    i_loopback,
  output logic                    o_t_busy,
  output logic                    o_r_busy,
  output logic                    o_rx_par_err,
  output logic                    o_rx_frame_err,
  output logic                    o_rx_overrun,
  output logic [lvl_w(DEPTH)-1:0] o_tx_level,
  output logic [lvl_w(DEPTH)-1:0] o_rx_level
);
  localparam int CW = $clog2(DIV + 1);
  tx_st_t        r_tx_st, w_tx_nxt;
  rx_st_t        r_rx_st, w_rx_nxt;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic [3:0]    r_tx_bit, r_rx_bit;
  logic [W-1:0]  r_tx_sh, r_rx_sh, w_txf_data, w_rxf_data;
  logic          r_tx_par, r_s1, r_s2, r_rx_pe, r_rx_fe, r_par_p, r_frm_p, r_ovr_p;
  logic          w_tx_tick, w_tx_pop, w_tx_line, w_txf_full, w_txf_empty;
  logic          w_rx_tick, w_rx_mid, w_rx_done, w_rx_ferr, w_rx_push, w_rx_src;
  logic          w_rxf_full, w_rxf_empty;
  fifo_buf #(.W(W), .DEPTH(DEPTH)) u_txf (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(i_tx_valid), .i_data(i_tx_data),
    .i_pop(w_tx_pop), .o_data(w_txf_data), .o_full(w_txf_full),
    .o_empty(w_txf_empty), .o_level(o_tx_level));
  fifo_buf #(.W(W), .DEPTH(DEPTH)) u_rxf (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_push(w_rx_push), .i_data(r_rx_sh),
    .i_pop(i_rx_ready), .o_data(w_rxf_data), .o_full(w_rxf_full),
    .o_empty(w_rxf_empty), .o_level(o_rx_level));
  assign o_tx_ready     = !w_txf_full;
  assign o_rx_data      = w_rxf_data;
  assign o_rx_valid     = !w_rxf_empty;
  assign o_t_busy       = r_tx_st != TX_IDLE;
  assign o_r_busy       = r_rx_st != RX_IDLE;
  assign o_rx_par_err   = r_par_p;
  assign o_rx_frame_err = r_frm_p;
  assign o_rx_overrun   = r_ovr_p;
  // Line decoded from state so reset forces it high without waiting for a clock.
  assign w_tx_line = (r_tx_st == TX_START) ? 1'b0 : (r_tx_st == TX_DATA) ? r_tx_sh[0] :
                     (r_tx_st == TX_PARITY) ? r_tx_par : 1'b1;
  assign o_tx      = w_tx_line | i_loopback;
  assign w_tx_tick = r_tx_cnt == CW'(DIV - 1);
  always_comb begin
    w_tx_nxt = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE: if (!w_txf_empty) begin
        w_tx_pop = 1'b1;
        w_tx_nxt = TX_START;
      end
      TX_START:  if (w_tx_tick) w_tx_nxt = TX_DATA;
      TX_DATA:   if (w_tx_tick && r_tx_bit == 4'(W - 1)) w_tx_nxt = (PAR != PAR_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_tick) w_tx_nxt = TX_STOP;
      TX_STOP:   if (w_tx_tick && r_tx_bit == 4'(STOP - 1)) begin
        // Chain straight into the next frame when more data is waiting.
        w_tx_pop = !w_txf_empty;
        w_tx_nxt = w_txf_empty ? TX_IDLE : TX_START;
      end
      default:   w_tx_nxt = TX_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
      r_tx_par <= 1'b0;
    end else begin
      r_tx_st  <= w_tx_nxt;
      r_tx_cnt <= (r_tx_st == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
      r_tx_bit <= (w_tx_nxt != r_tx_st) ? '0 : r_tx_bit + 4'(w_tx_tick);
      if (w_tx_pop) begin
        r_tx_sh  <= w_txf_data;
        r_tx_par <= ^w_txf_data ^ (PAR == PAR_ODD);
      end else if (r_tx_st == TX_DATA && w_tx_tick) r_tx_sh <= r_tx_sh >> 1;
    end
  assign w_rx_src  = i_loopback ? w_tx_line : i_rx;
  assign w_rx_tick = r_rx_cnt == CW'(DIV - 1);
  assign w_rx_mid  = r_rx_cnt == CW'(DIV / 2);
  assign w_rx_done = r_rx_st == RX_STOP && w_rx_tick && r_rx_bit == 4'(STOP - 1);
  assign w_rx_ferr = r_rx_fe | !r_s2;
  assign w_rx_push = w_rx_done && !w_rx_ferr;
  always_comb begin
    w_rx_nxt = r_rx_st;
    case (r_rx_st)
      RX_IDLE:   if (!r_s2) w_rx_nxt = RX_START;
      RX_START:  if (w_rx_mid) w_rx_nxt = r_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_tick && r_rx_bit == 4'(W - 1)) w_rx_nxt = (PAR != PAR_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_tick) w_rx_nxt = RX_STOP;
      RX_STOP:   if (w_rx_done) w_rx_nxt = RX_IDLE;
      default:   w_rx_nxt = RX_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_rx_st  <= RX_IDLE;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
      r_rx_pe  <= 1'b0;
      r_rx_fe  <= 1'b0;
      r_par_p  <= 1'b0;
      r_frm_p  <= 1'b0;
      r_ovr_p  <= 1'b0;
    end else begin
      r_s1     <= w_rx_src;
      r_s2     <= r_s1;
      r_rx_st  <= w_rx_nxt;
      // Idle parks the counter at 1 so the cycle that saw the low level counts
      // as cycle 0 of the start bit; the recheck then lands mid start bit.
      r_rx_cnt <= (r_rx_st == RX_IDLE) ? CW'(1) :
                  (w_rx_nxt != r_rx_st || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      r_rx_bit <= (w_rx_nxt != r_rx_st) ? '0 : r_rx_bit + 4'(w_rx_tick);
      if (r_rx_st == RX_IDLE) begin
        r_rx_pe <= 1'b0;
        r_rx_fe <= 1'b0;
      end
      if (r_rx_st == RX_DATA && w_rx_tick) r_rx_sh <= {r_s2, r_rx_sh[W-1:1]};
      if (r_rx_st == RX_PARITY && w_rx_tick) r_rx_pe <= r_s2 ^ ^r_rx_sh ^ (PAR == PAR_ODD);
      if (r_rx_st == RX_STOP && w_rx_tick && !r_s2) r_rx_fe <= 1'b1;
      r_par_p  <= w_rx_done && !w_rx_ferr && r_rx_pe;
      r_frm_p  <= w_rx_done && w_rx_ferr;
      r_ovr_p  <= w_rx_push && w_rxf_full;
    end
endmodule

// File: doc/uart_fifo.md
# uart_fifo

Buffered, parametrised UART transceiver; next-generation replacement for the row/column-addressed transmitter/receiver pair. Adds valid/ready streaming interfaces backed by TX and RX FIFOs, selectable parity mode and stop-bit count, mid-bit receive sampling with false-start rejection, error reporting and an internal loopback mode. Sits between the system datapath and the serial pins.

## Interface
- W, 8: data bits per frame, 5..9
- DIV, 3: clock cycles per bit, ≥ 2
- PAR, 0: 0 = none, 1 = even, 2 = odd
- STOP, 1: stop bits, 1 or 2
- DEPTH, 4: entries per FIFO, power of two ≥ 2
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- tx_data  in  W  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX FIFO not full
- rx_data  out  W  head of RX FIFO (show-ahead)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer accepts rx_data
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output
- loopback  in  1  1: receiver fed by internal tx line, tx pin held 1
- t_busy  out  1  transmitter mid-frame
- r_busy  out  1  receiver mid-frame
- rx_par_err  out  1  one-cycle pulse, parity mismatch
- rx_frame_err  out  1  one-cycle pulse, stop bit sampled 0
- rx_overrun  out  1  one-cycle pulse, word dropped, RX FIFO full
- tx_level, rx_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Frame: start bit 0, W data bits LSB first, parity bit if PAR≠0 (even: XOR of data; odd: inverted), STOP stop bits of 1; each bit DIV cycles. Frame length F = (1+W+(PAR≠0)+STOP)·DIV.
- TX FSM IDLE→START→DATA→PARITY (skipped if PAR=0)→STOP→IDLE. In IDLE with TX FIFO non-empty: pop, load shift register, enter START. At end of final stop bit, if FIFO non-empty go straight to START (no idle gap).
- tx_ready = !full; no same-cycle pop bypass. Push on tx_valid&&tx_ready.
- RX: rx (or internal tx when loopback=1) passes through a 2-flop synchroniser. RX FSM IDLE→START→DATA→PARITY→STOP→IDLE. In IDLE a synchronised 0 starts the bit counter; at count floor(DIV/2) input rechecked: 1 → false start, back to IDLE, nothing reported. Thereafter sample every DIV cycles: data, parity, each stop bit.
- After the last stop-bit sample the receiver returns to IDLE at that edge (mid-stop-bit) and completes the word:
  - any stop bit 0: rx_frame_err pulse, word discarded, parity not reported;
  - else parity mismatch: rx_par_err pulse, word still stored;
  - RX FIFO full: rx_overrun pulse, word dropped, FIFO contents unchanged. A pop in the same cycle does not prevent overrun.
- Pop RX FIFO on rx_valid&&rx_ready.

## Timing
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, t_busy=0, r_busy=0, all error pulses 0, levels 0; FSMs IDLE; FIFOs empty. Reset mid-frame aborts immediately, tx=1 asynchronously.
- Word accepted at edge N into empty idle TX: popped at edge N+1; tx low from N+1 for DIV cycles; t_busy high from N+1 until end of last stop bit.
- RX: word written to FIFO at final stop-bit sample edge; rx_valid high the cycle after. Loopback latency from tx falling to rx_valid: 2 (sync) + F − DIV + floor(DIV/2) + 1 cycles.
- r_busy high from start detection until return to IDLE.
- FIFO simultaneous push/pop: level unchanged; pointers wrap modulo DEPTH.

## Structure
- Shared package uart_pkg: parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), TX/RX state enums, level-width function.
- One sub-module, fifo_buf (W, DEPTH): synchronous show-ahead FIFO, instantiated twice. TX and RX FSMs inline.

## Test plan
- W=8, DIV=3, PAR=1, STOP=1, loopback=1, send 0xA5 → tx line bits 0,1,0,1,0,0,1,0,1,0(parity),1 at 3 cycles each; rx_data=0xA5, no error pulses.
- DEPTH=4, loopback=0, tx_valid held with 6 words 0x01..0x06 → 5 accepted before tx_ready falls; frames back-to-back, no idle cycles between them.
- Drive rx with 0x3C and parity bit 1 (wrong, even) → rx_par_err one pulse, rx_data=0x3C stored.
- Drive rx frame 0x55 with stop bit 0 → rx_frame_err pulse, rx_level stays 0.
- rx_ready=0, five loopback frames 0x10..0x14 → rx_level=4, one rx_overrun pulse on fifth, popping yields 0x10..0x13.
- rx low for 1 cycle while idle → no r_busy beyond false-start check, nothing stored; assert rst mid-TX frame → tx=1 immediately, levels 0.
